// File: rtl/spike_route_scheduler.sv
// Spike route scheduler: pops spiked-neuron IDs from the spike queue and presents each to the input router.
// Define ROUTE_TIMEOUT_EN to add a per-spike watchdog that abandons a spike after TimeoutLimit ROUTE cycles.
module spike_route_scheduler #(
  parameter int NEURON_WIDTH = 14,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    QueueEmpty,
  input  logic [NEURON_WIDTH-1:0] QueueData,
  output logic                    QueueRead,
  output logic                    RouteEnable,
  output logic [NEURON_WIDTH-1:0] NeuronID,
  input  logic                    RoutingComplete,
  input  logic [COUNT_WIDTH-1:0]  TimeoutLimit,
  output logic                    Busy,
  output logic                    PhaseDone,
  output logic [COUNT_WIDTH-1:0]  SpikeCount,
  output logic                    TimeoutError
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    ROUTE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;
  logic   timeout_hit;

`ifdef ROUTE_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] route_cycles;

  // Fires on the ROUTE cycle whose increment would bring the count up to the limit.
  assign timeout_hit = (TimeoutLimit != {COUNT_WIDTH{1'b0}}) &&
                       ((route_cycles + COUNT_WIDTH'(1)) == TimeoutLimit);

  // Watchdog counter: cleared on the way into ROUTE, counts every ROUTE cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      route_cycles <= {COUNT_WIDTH{1'b0}};
    end else if (state == LATCH) begin
      route_cycles <= {COUNT_WIDTH{1'b0}};
    end else if (state == ROUTE) begin
      route_cycles <= route_cycles + COUNT_WIDTH'(1);
    end else begin
      route_cycles <= route_cycles;
    end
  end
`else
  logic unused_limit;

  assign timeout_hit  = 1'b0;
  assign unused_limit = ^TimeoutLimit;
`endif

  // Phase sequencer; all outputs are registered alongside the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      QueueRead    <= 1'b0;
      RouteEnable  <= 1'b0;
      NeuronID     <= {NEURON_WIDTH{1'b0}};
      Busy         <= 1'b0;
      PhaseDone    <= 1'b0;
      SpikeCount   <= {COUNT_WIDTH{1'b0}};
      TimeoutError <= 1'b0;
    end else begin
      QueueRead <= 1'b0;
      PhaseDone <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            SpikeCount   <= {COUNT_WIDTH{1'b0}};
            TimeoutError <= 1'b0;
            Busy         <= 1'b1;
            if (QueueEmpty) begin
              state <= DONE;
            end else begin
              state     <= POP;
              QueueRead <= 1'b1;
            end
          end
        end
        POP: begin
          state <= LATCH;
        end
        // Popped data arrives one cycle after the strobe.
        LATCH: begin
          NeuronID    <= QueueData;
          RouteEnable <= 1'b1;
          state       <= ROUTE;
        end
        ROUTE: begin
          if (RoutingComplete) begin
            if (SpikeCount != {COUNT_WIDTH{1'b1}}) begin
              SpikeCount <= SpikeCount + COUNT_WIDTH'(1);
            end
            RouteEnable <= 1'b0;
            state       <= GAP;
          end else if (timeout_hit) begin
            TimeoutError <= 1'b1;
            RouteEnable  <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: begin
          if (QueueEmpty) begin
            state <= DONE;
          end else begin
            state     <= POP;
            QueueRead <= 1'b1;
          end
        end
        DONE: begin
          PhaseDone <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state       <= IDLE;
          RouteEnable <= 1'b0;
          Busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_route_scheduler.sv
// Scoreboard bench for spike_route_scheduler: directed phases push expected route pulses, phase ends and
// output snapshots; an independent monitor pops and compares them as the DUT presents its outputs.
module tb_spike_route_scheduler;
  localparam int NW = 14;
  localparam int CW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          QueueEmpty;
  logic [NW-1:0] QueueData = '0;
  logic          QueueRead;
  logic          RouteEnable;
  logic [NW-1:0] NeuronID;
  logic          RoutingComplete = 1'b0;
  logic [CW-1:0] TimeoutLimit = 16'd100;
  logic          Busy;
  logic          PhaseDone;
  logic [CW-1:0] SpikeCount;
  logic          TimeoutError;

  spike_route_scheduler #(.NEURON_WIDTH(NW), .COUNT_WIDTH(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .QueueEmpty(QueueEmpty), .QueueData(QueueData),
    .QueueRead(QueueRead), .RouteEnable(RouteEnable), .NeuronID(NeuronID),
    .RoutingComplete(RoutingComplete), .TimeoutLimit(TimeoutLimit), .Busy(Busy),
    .PhaseDone(PhaseDone), .SpikeCount(SpikeCount), .TimeoutError(TimeoutError)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Spike queue model: pop on QueueRead, data valid the following cycle.
  logic [NW-1:0] mem [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic flush  = 1'b0;
  assign QueueEmpty = (wr_ptr == rd_ptr);

  always @(posedge Clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (QueueRead === 1'b1) begin
      QueueData <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Router model: completes in the 11th cycle of RouteEnable (10 cycles after the rise); can hang on ID 7.
  logic hang_en = 1'b0;
  int   age = 0;
  initial begin
    forever begin
      @(negedge Clock);
      if (RouteEnable === 1'b1) age++;
      else age = 0;
      RoutingComplete = (age == 11) && !(hang_en && NeuronID == 14'd7);
    end
  end

  typedef struct { int cyc; logic [NW-1:0] id; } rise_t;
  typedef struct { int cyc; logic [CW-1:0] sc; logic te; } done_t;
  typedef struct { int cyc; string name; logic [34:0] val; } snap_t;
  rise_t rise_q[$];
  done_t done_q[$];
  snap_t snap_q[$];

  int   checks = 0;
  int   failures = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;
  logic [34:0] obs;
  assign obs = {QueueRead, RouteEnable, Busy, PhaseDone, TimeoutError, NeuronID, SpikeCount};

  // Monitor: compares everything the DUT presents against the scoreboard queues.
  initial begin
    rise_t r;
    done_t d;
    snap_t s;
    logic  re_prev;
    re_prev = 1'b0;
    forever begin
      @(negedge Clock);
      if (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        checks++;
        if (s.cyc != cyc || obs !== s.val) begin
          failures++;
          $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", s.name, obs, cyc, s.val, s.cyc);
        end
      end
      if (RouteEnable === 1'b1 && !re_prev) begin
        checks++;
        if (rise_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_route: got RouteEnable rise id=%0d at cycle %0d, expected none", NeuronID, cyc);
        end else begin
          r = rise_q.pop_front();
          if (r.cyc != cyc) begin
            failures++;
            $display("FAIL route_rise_cycle: got %0d, expected %0d", cyc, r.cyc);
          end
          checks++;
          if (NeuronID !== r.id) begin
            failures++;
            $display("FAIL route_id: got %0d, expected %0d", NeuronID, r.id);
          end
        end
      end
      re_prev = (RouteEnable === 1'b1);
      if (PhaseDone === 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_phase_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          d = done_q.pop_front();
          if (d.cyc != cyc) begin
            failures++;
            $display("FAIL phase_done_cycle: got %0d, expected %0d", cyc, d.cyc);
          end
          checks++;
          if (SpikeCount !== d.sc || TimeoutError !== d.te) begin
            failures++;
            $display("FAIL phase_result: got count=%0d terr=%b, expected count=%0d terr=%b",
                     SpikeCount, TimeoutError, d.sc, d.te);
          end
        end
      end
      if (QueueRead === 1'b1) begin
        checks++;
        if (QueueEmpty) begin
          failures++;
          $display("FAIL read_when_empty: got QueueRead=1 with QueueEmpty=1, expected 0 at cycle %0d", cyc);
        end
      end
      if (final_req && !final_done) begin
        final_done = 1'b1;
        checks++;
        if (rise_q.size() != 0) begin
          failures++;
          $display("FAIL missing_routes: got %0d outstanding, expected 0", rise_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
          failures++;
          $display("FAIL missing_phase_done: got %0d outstanding, expected 0", done_q.size());
        end
        checks++;
        if (snap_q.size() != 0) begin
          failures++;
          $display("FAIL missing_snapshots: got %0d outstanding, expected 0", snap_q.size());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic load(input logic [NW-1:0] id);
    mem[wr_ptr % 64] = id;
    wr_ptr++;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic exp_rise(input int c, input logic [NW-1:0] id);
    rise_t r;
    r.cyc = c;
    r.id  = id;
    rise_q.push_back(r);
  endtask

  task automatic exp_done(input int c, input logic [CW-1:0] sc, input logic te);
    done_t d;
    d.cyc = c;
    d.sc  = sc;
    d.te  = te;
    done_q.push_back(d);
  endtask

  // ctl order: {QueueRead, RouteEnable, Busy, PhaseDone, TimeoutError}
  task automatic exp_snap(input int c, input string name, input logic [4:0] ctl,
                          input logic [NW-1:0] nid, input logic [CW-1:0] sc);
    snap_t s;
    s.cyc  = c;
    s.name = name;
    s.val  = {ctl, nid, sc};
    snap_q.push_back(s);
  endtask

  initial begin
    int s, r1, r2, r3;
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    exp_snap(cyc + 1, "reset_state", 5'b00000, 14'd0, 16'd0);
    tick(3);

    // Empty queue: DONE next cycle, PhaseDone two cycles after Start, no routing.
    s = cyc;
    exp_snap(s + 1, "empty_done_state", 5'b00100, 14'd0, 16'd0);
    exp_done(s + 2, 16'd0, 1'b0);
    exp_snap(s + 3, "empty_after_pulse", 5'b00000, 14'd0, 16'd0);
    pulse_start();
    wait_cyc(s + 8);

    // Three spikes: rise 3 cycles after Start, 4 cycles after each RoutingComplete.
    load(14'd5); load(14'd900); load(14'd2049);
    tick(1);
    s = cyc; r1 = s + 3; r2 = r1 + 14; r3 = r2 + 14;
    exp_snap(s + 1, "pop_strobe", 5'b10100, 14'd0, 16'd0);
    exp_snap(s + 2, "latch_state", 5'b00100, 14'd0, 16'd0);
    exp_rise(r1, 14'd5); exp_rise(r2, 14'd900); exp_rise(r3, 14'd2049);
    exp_snap(r1 + 11, "gap_state", 5'b00100, 14'd5, 16'd1);
    exp_done(r3 + 13, 16'd3, 1'b0);
    exp_snap(r3 + 15, "idle_hold", 5'b00000, 14'd2049, 16'd3);
    pulse_start();
    wait_cyc(r3 + 20);

    // Start during ROUTE and coincident with RoutingComplete is ignored.
    load(14'd11); load(14'd12);
    tick(1);
    s = cyc; r1 = s + 3; r2 = r1 + 14;
    exp_rise(r1, 14'd11); exp_rise(r2, 14'd12);
    exp_done(r2 + 13, 16'd2, 1'b0);
    pulse_start();
    wait_cyc(s + 5);
    pulse_start();
    wait_cyc(r1 + 10);
    pulse_start();
    wait_cyc(r2 + 25);

    // Reset in ROUTE of the second spike aborts the phase with no PhaseDone.
    load(14'd21); load(14'd22); load(14'd23);
    tick(1);
    s = cyc; r1 = s + 3; r2 = r1 + 14;
    exp_rise(r1, 14'd21); exp_rise(r2, 14'd22);
    exp_snap(r2 + 3, "reset_abort", 5'b00000, 14'd0, 16'd0);
    pulse_start();
    wait_cyc(r2 + 2);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(20);

`ifdef ROUTE_TIMEOUT_EN
    // Watchdog: ID 7 never completes, abandoned after 8 ROUTE cycles; ID 30 still routed.
    TimeoutLimit = 16'd8;
    hang_en = 1'b1;
    load(14'd7); load(14'd30);
    tick(1);
    s = cyc; r1 = s + 3; r2 = r1 + 11;
    exp_rise(r1, 14'd7);
    exp_snap(r1 + 8, "timeout_gap", 5'b00101, 14'd7, 16'd0);
    exp_rise(r2, 14'd30);
    exp_done(r2 + 13, 16'd1, 1'b1);
    pulse_start();
    wait_cyc(r2 + 20);
`endif

    final_req = 1'b1;
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_route_scheduler.md
SPIKE_ROUTE_SCHEDULER -- requirements
Module: spike_route_scheduler

Interface
REQ-001 Parameter NEURON_WIDTH SHALL exist: default 14; width of neuron IDs.
REQ-002 Parameter COUNT_WIDTH SHALL exist: default 16; width of spike counter and timeout counter.
REQ-003 Port Clock SHALL be an input, 1 bit; rising-edge clock.
REQ-004 Port Reset SHALL be an input, 1 bit; Reset, synchronous, active-high; clock Clock.
REQ-005 Port Start SHALL be an input, 1 bit; begins one routing phase for the current timestep.
REQ-006 Port QueueEmpty SHALL be an input, 1 bit; spike queue empty flag.
REQ-007 Port QueueData SHALL be an input, NEURON_WIDTH bits; spiked-neuron ID, valid the cycle after QueueRead.
REQ-008 Port QueueRead SHALL be an output, 1 bit; pop strobe.
REQ-009 Port RouteEnable SHALL be an output, 1 bit; enables the input router.
REQ-010 Port NeuronID SHALL be an output, NEURON_WIDTH bits; ID presented to the router.
REQ-011 Port RoutingComplete SHALL be an input, 1 bit; router finished the current spike.
REQ-012 Port TimeoutLimit SHALL be an input, COUNT_WIDTH bits; watchdog limit in cycles.
REQ-013 Port Busy SHALL be an output, 1 bit; high whenever the FSM is not in IDLE.
REQ-014 Port PhaseDone SHALL be an output, 1 bit; one-cycle pulse at the end of the phase.
REQ-015 Port SpikeCount SHALL be an output, COUNT_WIDTH bits; spikes routed in the current phase.
REQ-016 Port TimeoutError SHALL be an output, 1 bit; sticky watchdog flag.

Function
REQ-017 The FSM SHALL have the states IDLE, POP, LATCH, ROUTE, GAP and DONE.
REQ-018 IDLE: on Start, clear SpikeCount and TimeoutError; go to DONE if QueueEmpty, else to POP. Start in any other state SHALL be ignored.
REQ-019 POP: QueueRead=1 for exactly one cycle, then go to LATCH.
REQ-020 LATCH: register NeuronID<=QueueData, then go to ROUTE.
REQ-021 NeuronID SHALL stay stable from LATCH until the next LATCH.
REQ-022 ROUTE: RouteEnable=1 and held. On RoutingComplete=1: SpikeCount+1, saturating at all-ones; go to GAP.
REQ-023 GAP: RouteEnable=0 for exactly one cycle, which re-arms the router. Then go to DONE if QueueEmpty, else to POP.
REQ-024 DONE: PhaseDone=1 for one cycle, then go to IDLE.
REQ-025 Start coincident with RoutingComplete SHALL have no effect outside IDLE.
REQ-026 QueueRead SHALL never assert while QueueEmpty=1.
REQ-027 Latency SHALL be: Start to first RouteEnable rise = 3 cycles; RoutingComplete to next RouteEnable rise = 4 cycles; empty queue Start to PhaseDone = 2 cycles.
REQ-028 SpikeCount and TimeoutError SHALL hold their values in IDLE until the next Start.

Reset
REQ-029 Reset SHALL force IDLE and drive QueueRead, RouteEnable, Busy, PhaseDone and TimeoutError to 0, and NeuronID and SpikeCount to 0.
REQ-030 Reset in mid-phase SHALL abort the phase without a PhaseDone pulse; a popped but unrouted ID is discarded.

Configuration
REQ-031 Macro ROUTE_TIMEOUT_EN defined: a counter clears on entering ROUTE and increments each ROUTE cycle.
REQ-032 With ROUTE_TIMEOUT_EN, if TimeoutLimit!=0 and the count reaches TimeoutLimit without RoutingComplete: set TimeoutError, do not increment SpikeCount, go to GAP.
REQ-033 Macro ROUTE_TIMEOUT_EN undefined: TimeoutError is tied to 0, TimeoutLimit is ignored, and ROUTE waits indefinitely; ports SHALL be unchanged.

Verification
REQ-034 Queue empty, pulse Start -> PhaseDone one cycle, 2 cycles later; SpikeCount=0; RouteEnable never high.
REQ-035 Queue holds IDs 5, 900, 2049; router completes 10 cycles after each rise -> three RouteEnable pulses with NeuronID 5, 900, 2049; one-cycle gaps; SpikeCount=3; single PhaseDone.
REQ-036 Start pulsed during ROUTE -> ignored; phase completes once.
REQ-037 Reset asserted in ROUTE of the 2nd of 3 spikes -> next cycle all outputs 0 and IDLE; no PhaseDone.
REQ-038 With ROUTE_TIMEOUT_EN, TimeoutLimit=8, router never completes ID 7 -> RouteEnable drops after 8 ROUTE cycles; TimeoutError=1; SpikeCount unchanged; next queue entry still routed.
